fifo_flex: RTL and testbench

FIFO_FLEX -- requirements
Module: fifo_flex

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_flex_if.sv | 25 ++
 rtl/fifo_wrap_ptr.sv | 34 +++
 rtl/fifo_flex.sv | 107 ++++++++++
 tb/tb_fifo_flex.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared width helpers and default parameters for the fifo_flex family.
package fifo_pkg;

    localparam int unsigned DefDepth       = 5;
    localparam int unsigned DefDataW       = 32;
    localparam int unsigned DefAemptyTh    = 1;
    localparam int unsigned DefFallThrough = 0;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_flex_if.sv
// Push/pop handshake bundle; the FIFO sits on the slave modport.
interface fifo_flex_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW
);

    logic              f_valid_in;
    logic [DATA_W-1:0] f_data_in;
    logic              f_ready_out;
    logic              b_valid_out;
    logic [DATA_W-1:0] b_data_out;
    logic              b_ready_in;

    modport master (
        output f_valid_in, f_data_in, b_ready_in,
        input  f_ready_out, b_valid_out, b_data_out
    );

    modport slave (
        input  f_valid_in, f_data_in, b_ready_in,
        output f_ready_out, b_valid_out, b_data_out
    );

endinterface

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer with increment and synchronous clear.
module fifo_wrap_ptr #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_flex.sv
// Synchronous FIFO of arbitrary depth with flush, thresholds and optional empty bypass.
module fifo_flex
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH        = DefDepth,
    parameter int unsigned DATA_W       = DefDataW,
    parameter int unsigned AFULL_TH     = DEPTH - 1,
    parameter int unsigned AEMPTY_TH    = DefAemptyTh,
    parameter int unsigned FALL_THROUGH = DefFallThrough
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    fifo_flex_if.slave                  bus,
    output logic [cnt_w(DEPTH)-1:0]     count,
    output logic                        almost_full,
    output logic                        almost_empty
);

    localparam int unsigned PtrW = ptr_w(DEPTH);
    localparam int unsigned CntW = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [CntW-1:0]   count_q, count_d;
    logic              af_q, af_d, ae_q, ae_d;
    logic [PtrW-1:0]   wr_ptr, rd_ptr;
    logic              bypass, push, pop, wr_en, rd_en;

    always_comb begin
        bypass          = (FALL_THROUGH != 0) && (count_q == '0) && !flush;
        bus.f_ready_out = (count_q != CntW'(DEPTH)) && !flush;
        bus.b_valid_out = bypass ? bus.f_valid_in : ((count_q != '0) && !flush);
        bus.b_data_out  = bypass ? bus.f_data_in : mem_q[rd_ptr];
        push            = bus.f_valid_in && bus.f_ready_out;
        pop             = bus.b_valid_out && bus.b_ready_in;
        // A bypassed word that is popped in the same cycle never touches storage.
        wr_en           = push && !(bypass && pop);
        rd_en           = pop && !bypass;
    end

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr] = bus.f_data_in;
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            unique case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
        af_d = (count_d >= CntW'(AFULL_TH));
        ae_d = (count_d <= CntW'(AEMPTY_TH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            af_q    <= (AFULL_TH == 0);
            ae_q    <= 1'b1;
        end else begin
            count_q <= count_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    fifo_wrap_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PtrW)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (wr_en),
        .ptr (wr_ptr)
    );

    fifo_wrap_ptr #(
        .DEPTH (DEPTH),
        .PTR_W (PtrW)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (rd_en),
        .ptr (rd_ptr)
    );

    assign count        = count_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

endmodule

// File: tb/tb_fifo_flex.sv
// Directed table-driven bench for fifo_flex: normal-mode DUT plus a fall-through DUT.
module tb_fifo_flex;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] count0, count1;
    logic       af0, ae0, af1, ae1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    fifo_flex_if #(.DATA_W(8)) bus0 ();
    fifo_flex_if #(.DATA_W(8)) bus1 ();

    fifo_flex #(
        .DEPTH        (5),
        .DATA_W       (8),
        .AFULL_TH     (4),
        .AEMPTY_TH    (1),
        .FALL_THROUGH (0)
    ) dut0 (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bus          (bus0),
        .count        (count0),
        .almost_full  (af0),
        .almost_empty (ae0)
    );

    fifo_flex #(
        .DEPTH        (5),
        .DATA_W       (8),
        .AFULL_TH     (4),
        .AEMPTY_TH    (1),
        .FALL_THROUGH (1)
    ) dut1 (
        .clk          (clk),
        .rst          (rst),
        .flush        (1'b0),
        .bus          (bus1),
        .count        (count1),
        .almost_full  (af1),
        .almost_empty (ae1)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       f;
        int         c;
        logic       rdy;
        logic       bv;
        logic       chkd;
        logic [7:0] bd;
        logic       af;
        logic       ae;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [7:0] d, input logic r, input logic f,
                       input int c, input logic rdy, input logic bv, input logic chkd,
                       input logic [7:0] bd, input logic af, input logic ae);
        vec_t t;
        t = '{v: v, d: d, r: r, f: f, c: c, rdy: rdy, bv: bv, chkd: chkd, bd: bd,
              af: af, ae: ae};
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, before the next rise.
    task automatic drive(input logic v0, input logic [7:0] d0, input logic r0, input logic f,
                         input logic v1, input logic [7:0] d1, input logic r1);
        @(negedge clk);
        bus0.f_valid_in = v0;
        bus0.f_data_in  = d0;
        bus0.b_ready_in = r0;
        flush           = f;
        bus1.f_valid_in = v1;
        bus1.f_data_in  = d1;
        bus1.b_ready_in = r1;
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        bus0.f_valid_in = 1'b0; bus0.f_data_in = '0; bus0.b_ready_in = 1'b0;
        bus1.f_valid_in = 1'b0; bus1.f_data_in = '0; bus1.b_ready_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset count", 32'(count0), 0);
        chk("reset ready", 32'(bus0.f_ready_out), 1);
        chk("reset bvalid", 32'(bus0.b_valid_out), 0);
        chk("reset afull", 32'(af0), 0);
        chk("reset aempty", 32'(ae0), 1);
        chk("reset ft bvalid", 32'(bus1.b_valid_out), 0);

        //   v  d      r  f  cnt rdy bv chkd bd    af ae
        add(1, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 1);
        add(1, 8'h01, 0, 0, 1, 1, 1, 1, 8'h00, 0, 1);
        add(1, 8'h02, 0, 0, 2, 1, 1, 1, 8'h00, 0, 0);
        add(1, 8'h03, 0, 0, 3, 1, 1, 1, 8'h00, 0, 0);
        add(1, 8'h04, 0, 0, 4, 1, 1, 1, 8'h00, 1, 0);
        add(1, 8'h05, 0, 0, 5, 0, 1, 1, 8'h00, 1, 0);
        add(0, 8'h00, 1, 0, 5, 0, 1, 1, 8'h00, 1, 0);
        add(0, 8'h00, 1, 0, 4, 1, 1, 1, 8'h01, 1, 0);
        add(0, 8'h00, 1, 0, 3, 1, 1, 1, 8'h02, 0, 0);
        add(0, 8'h00, 1, 0, 2, 1, 1, 1, 8'h03, 0, 0);
        add(0, 8'h00, 1, 0, 1, 1, 1, 1, 8'h04, 0, 1);
        add(0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 1);
        add(1, 8'h10, 0, 0, 0, 1, 0, 0, 8'h00, 0, 1);
        add(1, 8'h11, 0, 0, 1, 1, 1, 1, 8'h10, 0, 1);
        add(1, 8'h12, 0, 0, 2, 1, 1, 1, 8'h10, 0, 0);
        add(1, 8'h13, 1, 0, 3, 1, 1, 1, 8'h10, 0, 0);
        add(0, 8'h00, 0, 0, 3, 1, 1, 1, 8'h11, 0, 0);
        add(1, 8'h14, 0, 0, 3, 1, 1, 1, 8'h11, 0, 0);
        add(1, 8'h15, 0, 0, 4, 1, 1, 1, 8'h11, 1, 0);
        add(1, 8'h16, 1, 0, 5, 0, 1, 1, 8'h11, 1, 0);
        add(0, 8'h00, 0, 0, 4, 1, 1, 1, 8'h12, 1, 0);
        add(1, 8'h77, 0, 1, 4, 0, 0, 0, 8'h00, 1, 0);
        add(0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 1);
        add(1, 8'h20, 0, 0, 0, 1, 0, 0, 8'h00, 0, 1);
        add(0, 8'h00, 1, 0, 1, 1, 1, 1, 8'h20, 0, 1);
        add(0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h00, 0, 1);
        add(0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].f, 1'b0, 8'h00, 1'b0);
            chk($sformatf("row%0d count", i), 32'(count0), 32'(vecs[i].c));
            chk($sformatf("row%0d ready", i), 32'(bus0.f_ready_out), 32'(vecs[i].rdy));
            chk($sformatf("row%0d bvalid", i), 32'(bus0.b_valid_out), 32'(vecs[i].bv));
            chk($sformatf("row%0d afull", i), 32'(af0), 32'(vecs[i].af));
            chk($sformatf("row%0d aempty", i), 32'(ae0), 32'(vecs[i].ae));
            if (vecs[i].chkd) begin
                chk($sformatf("row%0d bdata", i), 32'(bus0.b_data_out), 32'(vecs[i].bd));
            end
        end

        // Twelve push/pop pairs walk both pointers through 4->0 twice.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            chk($sformatf("wrap%0d pre count", i), 32'(count0), 0);
            drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            chk($sformatf("wrap%0d count", i), 32'(count0), 1);
            chk($sformatf("wrap%0d bdata", i), 32'(bus0.b_data_out), 32'(8'h30 + i));
        end

        // Fall-through: same-cycle bypass, then a stored word.
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1);
        chk("ft bypass bvalid", 32'(bus1.b_valid_out), 1);
        chk("ft bypass bdata", 32'(bus1.b_data_out), 32'hA5);
        chk("ft bypass count", 32'(count1), 0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("ft after bypass count", 32'(count1), 0);
        chk("ft after bypass bvalid", 32'(bus1.b_valid_out), 0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA6, 1'b0);
        chk("ft offer bdata", 32'(bus1.b_data_out), 32'hA6);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("ft stored count", 32'(count1), 1);
        chk("ft stored bdata", 32'(bus1.b_data_out), 32'hA6);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("ft drained count", 32'(count1), 0);
        chk("ft drained bvalid", 32'(bus1.b_valid_out), 0);

        // Reset in the middle of traffic discards stored data.
        drive(1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("pre-rst count", 32'(count0), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid rst count", 32'(count0), 0);
        chk("mid rst bvalid", 32'(bus0.b_valid_out), 0);
        chk("mid rst ready", 32'(bus0.f_ready_out), 1);
        chk("mid rst aempty", 32'(ae0), 1);
        chk("mid rst afull", 32'(af0), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
